// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and forwarding controller for a 5-stage MIPS-style pipeline.
// It keeps a shift-register scoreboard of in-flight destinations behind ID.
// From that scoreboard it produces stall/flush/bubble controls, registered
// EX forward selects, ID write-back bypass flags and saturating performance
// counters.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   id_valid             ID holds a real instruction
//   rs_id, rt_id         ID source registers; use_rs_id/use_rt_id qualify them
//   wn_id                ID destination; regwrite_id / memread_id qualify it
//   redirect             taken branch/jump resolved in stage BR_STAGE
//   en_pc, en_ifid       PC and IF/ID write enables
//   flush_ifid           clear IF/ID to nop
//   bubble_idex          load a nop into ID/EX
//   fwd_a_ex, fwd_b_ex   registered forward selects (k = result of stage k+1)
//   byp_a_id, byp_b_id   ID sources must take rfile_wd (WB-stage match)
//   stall_cnt, flush_cnt saturating event counters
module pipe_hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int RADDR_W  = 5,
    parameter int BR_STAGE = 2,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 16,
    localparam int FWD_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] rs_id,
    input  logic [RADDR_W-1:0] rt_id,
    input  logic               use_rs_id,
    input  logic               use_rt_id,
    input  logic [RADDR_W-1:0] wn_id,
    input  logic               regwrite_id,
    input  logic               memread_id,
    input  logic               redirect,
    output logic               en_pc,
    output logic               en_ifid,
    output logic               flush_ifid,
    output logic               bubble_idex,
    output logic [FWD_W-1:0]   fwd_a_ex,
    output logic [FWD_W-1:0]   fwd_b_ex,
    output logic               byp_a_id,
    output logic               byp_b_id,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Scoreboard: index 1 is the instruction now in EX, DEPTH is WB.
    // Only the EX entry's load flag is ever consulted, so only it is stored.
    logic               sb_v  [1:DEPTH];
    logic               sb_rw [1:DEPTH];
    logic [RADDR_W-1:0] sb_wn [1:DEPTH];
    logic               sb_ld1;

    logic [DEPTH:1]     hit_a;
    logic [DEPTH:1]     hit_b;
    logic               use_a;
    logic               use_b;
    logic               stall;
    logic               advance;
    logic [FWD_W-1:0]   near_a;
    logic [FWD_W-1:0]   near_b;

    assign use_a = id_valid & use_rs_id;
    assign use_b = id_valid & use_rt_id;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            hit_a[k] = use_a & sb_v[k] & sb_rw[k] & (sb_wn[k] != '0) & (sb_wn[k] == rs_id);
            hit_b[k] = use_b & sb_v[k] & sb_rw[k] & (sb_wn[k] != '0) & (sb_wn[k] == rt_id);
        end
    end

    generate
        if (FWD_EN != 0) begin : g_fwd
            assign stall = sb_ld1 & (hit_a[1] | hit_b[1]);
        end else begin : g_nofwd
            // WB is excluded: the bypass covers the write-at-edge case.
            assign stall = (|hit_a[DEPTH-1:1]) | (|hit_b[DEPTH-1:1]);
        end
    endgenerate

    // Scan from oldest to youngest so the nearest producer is written last.
    always_comb begin
        near_a = '0;
        near_b = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (hit_a[k]) near_a = FWD_W'(k);
            if (hit_b[k]) near_b = FWD_W'(k);
        end
    end

    // A redirect overrides a stall: the stalled instruction is wrong-path.
    assign advance     = ~stall & ~redirect;
    assign en_pc       = redirect | ~stall;
    assign en_ifid     = redirect | ~stall;
    assign flush_ifid  = redirect;
    assign bubble_idex = redirect | stall;
    assign byp_a_id    = hit_a[DEPTH];
    assign byp_b_id    = hit_b[DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) sb_v[k] <= 1'b0;
            fwd_a_ex  <= '0;
            fwd_b_ex  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb_v[1] <= id_valid & advance;
            // Entries younger than the branch are wrong-path on a redirect.
            for (int k = 1; k < DEPTH; k++)
                sb_v[k+1] <= sb_v[k] & ~(redirect & (k < BR_STAGE));

            if ((FWD_EN != 0) && advance) begin
                fwd_a_ex <= near_a;
                fwd_b_ex <= near_b;
            end else begin
                fwd_a_ex <= '0;
                fwd_b_ex <= '0;
            end

            if (stall && !redirect && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // Payload fields are qualified by sb_v, so they need no reset.
    always_ff @(posedge clk) begin
        sb_wn[1] <= wn_id;
        sb_rw[1] <= regwrite_id;
        sb_ld1   <= memread_id;
        for (int k = 1; k < DEPTH; k++) begin
            sb_wn[k+1] <= sb_wn[k];
            sb_rw[k+1] <= sb_rw[k];
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int DEPTH = 3;
    localparam int RW    = 5;
    localparam int BRS   = 2;
    localparam int CW    = 4;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int SAT   = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, id_valid, use_rs_id, use_rt_id, regwrite_id, memread_id, redirect;
    logic [RW-1:0] rs_id, rt_id, wn_id;

    logic [1:0]    en_pc, en_ifid, flush_ifid, bubble_idex, byp_a_id, byp_b_id;
    logic [FW-1:0] fwd_a_ex [2];
    logic [FW-1:0] fwd_b_ex [2];
    logic [CW-1:0] stall_cnt [2];
    logic [CW-1:0] flush_cnt [2];

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .RADDR_W(RW), .BR_STAGE(BRS), .FWD_EN(1), .CNT_W(CW)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .wn_id(wn_id),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .redirect(redirect),
        .en_pc(en_pc[0]), .en_ifid(en_ifid[0]), .flush_ifid(flush_ifid[0]),
        .bubble_idex(bubble_idex[0]), .fwd_a_ex(fwd_a_ex[0]), .fwd_b_ex(fwd_b_ex[0]),
        .byp_a_id(byp_a_id[0]), .byp_b_id(byp_b_id[0]),
        .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]));

    pipe_hazard_ctrl #(.DEPTH(DEPTH), .RADDR_W(RW), .BR_STAGE(BRS), .FWD_EN(0), .CNT_W(CW)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .wn_id(wn_id),
        .regwrite_id(regwrite_id), .memread_id(memread_id), .redirect(redirect),
        .en_pc(en_pc[1]), .en_ifid(en_ifid[1]), .flush_ifid(flush_ifid[1]),
        .bubble_idex(bubble_idex[1]), .fwd_a_ex(fwd_a_ex[1]), .fwd_b_ex(fwd_b_ex[1]),
        .byp_a_id(byp_a_id[1]), .byp_b_id(byp_b_id[1]),
        .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]));

    // Reference model: every instruction that left ID, tagged with the cycle
    // it left; its pipeline stage is simply its age in cycles.
    typedef struct {
        int            inst;
        int            issue;
        logic [RW-1:0] wn;
        bit            rw;
        bit            ld;
        bit            alive;
    } rec_t;

    typedef struct {
        bit en_pc, en_ifid, flush, bubble, ba, bb;
        int fa, fb, sc, fc;
    } exp_t;

    rec_t recs[$];
    exp_t expq0[$];
    exp_t expq1[$];
    int   m_fa[2], m_fb[2], m_sc[2], m_fc[2];
    int   cyc;
    int   checks;
    int   errors;

    function automatic bit m_at(int inst, int age, logic [RW-1:0] r, bit need_ld);
        foreach (recs[j])
            if (recs[j].inst == inst && recs[j].alive && (cyc - recs[j].issue) == age &&
                recs[j].rw && recs[j].wn != 0 && recs[j].wn == r && (!need_ld || recs[j].ld))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int nearest(int inst, logic [RW-1:0] r);
        for (int k = 1; k < DEPTH; k++)
            if (m_at(inst, k, r, 1'b0)) return k;
        return 0;
    endfunction

    task automatic model_step();
        bit   fe, ua, ub, st;
        int   na, nb;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            fe = (i == 0);
            ua = id_valid && use_rs_id;
            ub = id_valid && use_rt_id;
            st = 1'b0;
            if (fe) begin
                st = (ua && m_at(i, 1, rs_id, 1'b1)) || (ub && m_at(i, 1, rt_id, 1'b1));
            end else begin
                for (int k = 1; k < DEPTH; k++)
                    if ((ua && m_at(i, k, rs_id, 1'b0)) || (ub && m_at(i, k, rt_id, 1'b0)))
                        st = 1'b1;
            end
            e.en_pc   = redirect || !st;
            e.en_ifid = redirect || !st;
            e.flush   = redirect;
            e.bubble  = redirect || st;
            e.ba      = ua && m_at(i, DEPTH, rs_id, 1'b0);
            e.bb      = ub && m_at(i, DEPTH, rt_id, 1'b0);
            e.fa      = m_fa[i];
            e.fb      = m_fb[i];
            e.sc      = m_sc[i];
            e.fc      = m_fc[i];
            if (i == 0) expq0.push_back(e);
            else        expq1.push_back(e);

            na = ua ? nearest(i, rs_id) : 0;
            nb = ub ? nearest(i, rt_id) : 0;
            if (rst) begin
                for (int j = recs.size() - 1; j >= 0; j--)
                    if (recs[j].inst == i) recs.delete(j);
                m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (redirect)
                    foreach (recs[j])
                        if (recs[j].inst == i && (cyc - recs[j].issue) >= 1 &&
                            (cyc - recs[j].issue) < BRS)
                            recs[j].alive = 1'b0;
                m_fa[i] = (fe && !st && !redirect) ? na : 0;
                m_fb[i] = (fe && !st && !redirect) ? nb : 0;
                if (!st && !redirect && id_valid)
                    recs.push_back('{i, cyc, wn_id, regwrite_id, memread_id, 1'b1});
                if (st && !redirect && m_sc[i] < SAT) m_sc[i]++;
                if (redirect && m_fc[i] < SAT) m_fc[i]++;
            end
        end
        cyc++;
        for (int j = recs.size() - 1; j >= 0; j--)
            if (cyc - recs[j].issue > DEPTH) recs.delete(j);
    endtask

    task automatic drive(input bit r, input bit v, input int a, input int b,
                         input bit ua, input bit ub, input int w,
                         input bit rwr, input bit ld, input bit rd);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; rs_id = RW'(a); rt_id = RW'(b);
        use_rs_id = ua; use_rt_id = ub; wn_id = RW'(w);
        regwrite_id = rwr; memread_id = ld; redirect = rd;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmp(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst=%0d cycle=%0d got=%0h want=%0h", nm, inst, cyc, act, req);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq0.size() > 0) begin
            e = expq0.pop_front();
            cmp("en_pc", 0, 32'(en_pc[0]), 32'(e.en_pc));
            cmp("en_ifid", 0, 32'(en_ifid[0]), 32'(e.en_ifid));
            cmp("flush_ifid", 0, 32'(flush_ifid[0]), 32'(e.flush));
            cmp("bubble_idex", 0, 32'(bubble_idex[0]), 32'(e.bubble));
            cmp("fwd_a_ex", 0, 32'(fwd_a_ex[0]), e.fa);
            cmp("fwd_b_ex", 0, 32'(fwd_b_ex[0]), e.fb);
            cmp("byp_a_id", 0, 32'(byp_a_id[0]), 32'(e.ba));
            cmp("byp_b_id", 0, 32'(byp_b_id[0]), 32'(e.bb));
            cmp("stall_cnt", 0, 32'(stall_cnt[0]), e.sc);
            cmp("flush_cnt", 0, 32'(flush_cnt[0]), e.fc);
        end
        if (expq1.size() > 0) begin
            e = expq1.pop_front();
            cmp("en_pc", 1, 32'(en_pc[1]), 32'(e.en_pc));
            cmp("en_ifid", 1, 32'(en_ifid[1]), 32'(e.en_ifid));
            cmp("flush_ifid", 1, 32'(flush_ifid[1]), 32'(e.flush));
            cmp("bubble_idex", 1, 32'(bubble_idex[1]), 32'(e.bubble));
            cmp("fwd_a_ex", 1, 32'(fwd_a_ex[1]), e.fa);
            cmp("fwd_b_ex", 1, 32'(fwd_b_ex[1]), e.fb);
            cmp("byp_a_id", 1, 32'(byp_a_id[1]), 32'(e.ba));
            cmp("byp_b_id", 1, 32'(byp_b_id[1]), 32'(e.bb));
            cmp("stall_cnt", 1, 32'(stall_cnt[1]), e.sc);
            cmp("flush_cnt", 1, 32'(flush_cnt[1]), e.fc);
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        rst = 1'b1; id_valid = 1'b0; rs_id = '0; rt_id = '0; use_rs_id = 1'b0;
        use_rt_id = 1'b0; wn_id = '0; regwrite_id = 1'b0; memread_id = 1'b0; redirect = 1'b0;

        // Reset, then idle so the post-reset state is observed.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Load-use: lw $2 ; add $3,$2,$4 held while stalled.
        drive(0, 1, 0, 0, 0, 0, 2, 1, 1, 0);
        drive(0, 1, 2, 4, 1, 1, 3, 1, 0, 0);
        drive(0, 1, 2, 4, 1, 1, 3, 1, 0, 0);
        drive(0, 1, 2, 4, 1, 1, 3, 1, 0, 0);
        idle(4);

        // ALU chain and a consumer three behind (WB bypass).
        drive(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        drive(0, 1, 5, 5, 1, 1, 6, 1, 0, 0);
        drive(0, 1, 1, 1, 1, 1, 7, 1, 0, 0);
        drive(0, 1, 5, 0, 1, 0, 8, 1, 0, 0);
        idle(4);

        // Redirect while a load-use stall is pending.
        drive(0, 1, 0, 0, 0, 0, 7, 1, 1, 0);
        drive(0, 1, 7, 7, 1, 1, 9, 1, 0, 1);
        drive(0, 1, 7, 7, 1, 1, 9, 1, 0, 0);
        idle(4);

        // $0 destination never creates a hazard.
        drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 1, 0, 0, 1, 1, 9, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 9, 1, 0, 0);
        idle(4);

        // Many stalls to saturate the narrow counters, then reset mid-stall.
        for (int n = 0; n < 20; n++) begin
            drive(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
            drive(0, 1, 1, 1, 1, 1, 2, 1, 0, 0);
            drive(0, 1, 1, 1, 1, 1, 2, 1, 0, 1);
        end
        drive(0, 1, 0, 0, 0, 0, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 1, 1, 2, 1, 0, 0);
        drive(0, 1, 1, 1, 1, 1, 2, 1, 0, 0);
        idle(3);

        // Randomised traffic over a small register set to provoke matches.
        for (int n = 0; n < 2000; n++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 85),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 12));
        end
        idle(1);

        repeat (3) @(negedge clk);
        checks++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d want=0", expq0.size(), expq1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
